// File: rtl/cache_pkg.sv
// Shared definitions for the DRAM cache request path: state encoding,
// arbitration modes and descriptor layout helpers.
package cache_pkg;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } cache_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_RDPRI = 1;

  // Descriptor layout, LSB first: address, ID, then is_write in the MSB.
  function automatic int desc_width(input int addr_w, input int id_w);
    return addr_w + id_w + 1;
  endfunction

  function automatic int desc_id_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int desc_wr_bit(input int addr_w, input int id_w);
    return addr_w + id_w;
  endfunction

endpackage

// File: rtl/cache_idx_fn.sv
// Combinational set-index extraction, shared with the tag path.
// CACHE_IDX_HASH_EN folds the next index-sized field above the index into it.
module cache_idx_fn #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = 4,
  parameter int INDEX_LSB   = 6
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic [INDEX_WIDTH-1:0] index_o
);

`ifdef CACHE_IDX_HASH_EN
  assign index_o = addr_i[INDEX_LSB +: INDEX_WIDTH]
                 ^ addr_i[INDEX_LSB + INDEX_WIDTH +: INDEX_WIDTH];
`else
  assign index_o = addr_i[INDEX_LSB +: INDEX_WIDTH];
`endif

  // Most address bits are intentionally ignored here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

endmodule

// File: rtl/cache_req_arbiter.sv
// AR/AW request arbiter feeding the cache request FIFO, with drain control.
// Build option CACHE_IDX_HASH_EN selects the hashed set index.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int ID_WIDTH    = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int INDEX_LSB   = 6,
  parameter int ARB_MODE    = 0,
  parameter int STARVE_MAX  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ID_WIDTH-1:0]            arid_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  input  logic [ID_WIDTH-1:0]            awid_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic                           drain_i,
  output logic                           idle_o,
  output logic [INDEX_WIDTH-1:0]         index_o,
  input  logic                           fifo_afull_i,
  output logic                           fifo_write_en_o,
  output logic [ADDR_WIDTH+ID_WIDTH:0]   fifo_data_o
);

  localparam int DW     = desc_width(ADDR_WIDTH, ID_WIDTH);
  localparam int ID_LSB = desc_id_lsb(ADDR_WIDTH);
  localparam int WR_BIT = desc_wr_bit(ADDR_WIDTH, ID_WIDTH);
  localparam int SW     = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  localparam logic [0:0] ST_RUN   = S_RUN;
  localparam logic [0:0] ST_DRAIN = S_DRAIN;

  logic [0:0]             state_q, state_d;
  logic                   last_aw_q, last_aw_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   wr_en_q;
  logic [DW-1:0]          data_q, data_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;

  logic                   accept_en;
  logic                   gnt_aw;
  logic                   ar_hs, aw_hs;
  logic [ADDR_WIDTH-1:0]  sel_addr;

  assign accept_en = (state_q == ST_RUN) && !fifo_afull_i && !drain_i;

  always_comb begin
    gnt_aw = 1'b0;
    if (awvalid_i && !arvalid_i) begin
      gnt_aw = 1'b1;
    end else if (awvalid_i && arvalid_i) begin
      if (ARB_MODE == ARB_RDPRI) begin
        gnt_aw = (starve_q == STARVE_TOP);
      end else begin
        gnt_aw = !last_aw_q;
      end
    end
  end

  // Readies are forced low during reset, independent of register state.
  assign arready_o = rst_n && accept_en && arvalid_i && !gnt_aw;
  assign awready_o = rst_n && accept_en && awvalid_i && gnt_aw;
  assign ar_hs     = arready_o;
  assign aw_hs     = awready_o;

  assign sel_addr = gnt_aw ? awaddr_i : araddr_i;

  cache_idx_fn #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .INDEX_LSB   (INDEX_LSB)
  ) u_idx (
    .addr_i  (sel_addr),
    .index_o (idx_d)
  );

  always_comb begin
    data_d                         = '0;
    data_d[WR_BIT]                 = gnt_aw;
    data_d[ID_LSB +: ID_WIDTH]     = gnt_aw ? awid_i : arid_i;
    data_d[ADDR_WIDTH-1:0]         = sel_addr;
  end

  always_comb begin
    starve_d  = starve_q;
    last_aw_d = last_aw_q;
    if (aw_hs) begin
      starve_d  = '0;
      last_aw_d = 1'b1;
    end else if (ar_hs) begin
      last_aw_d = 1'b0;
      if (awvalid_i && (starve_q != STARVE_TOP)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i)  state_d = ST_DRAIN;
      ST_DRAIN: if (!drain_i) state_d = ST_RUN;
      default:                state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      last_aw_q <= 1'b1;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_aw_q <= last_aw_d;
      starve_q  <= starve_d;
      wr_en_q   <= ar_hs || aw_hs;
      if (ar_hs || aw_hs) begin
        data_q <= data_d;
        idx_q  <= idx_d;
      end
    end
  end

  assign fifo_write_en_o = wr_en_q;
  assign fifo_data_o     = data_q;
  assign index_o         = idx_q;
  assign idle_o          = !wr_en_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: a round-robin and a read-priority instance
// driven by the same directed stimulus, checked against a reference model.
module tb_cache_req_arbiter;

  localparam int AW_W = 64;
  localparam int ID_W = 16;
  localparam int IX_W = 4;
  localparam int DW   = AW_W + ID_W + 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n   = 1'b0;
  logic            arvalid = 1'b0;
  logic            awvalid = 1'b0;
  logic            afull   = 1'b0;
  logic            drain   = 1'b0;
  logic [ID_W-1:0] arid    = 16'h0005;
  logic [ID_W-1:0] awid    = 16'hB0B2;
  logic [AW_W-1:0] araddr  = 64'h0000_0000_0000_1A40;
  logic [AW_W-1:0] awaddr  = 64'hFFFF_0000_DEAD_BE40;

  logic            arready [2];
  logic            awready [2];
  logic            idle    [2];
  logic            wr_en   [2];
  logic [IX_W-1:0] index   [2];
  logic [DW-1:0]   fdata   [2];

  int cmp_cnt = 0;
  int err_cnt = 0;

  cache_req_arbiter #(.ARB_MODE(0), .STARVE_MAX(SMAX)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[0]),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready[0]),
    .drain_i(drain), .idle_o(idle[0]), .index_o(index[0]),
    .fifo_afull_i(afull), .fifo_write_en_o(wr_en[0]), .fifo_data_o(fdata[0])
  );

  cache_req_arbiter #(.ARB_MODE(1), .STARVE_MAX(SMAX)) u_rp (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[1]),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready[1]),
    .drain_i(drain), .idle_o(idle[1]), .index_o(index[1]),
    .fifo_afull_i(afull), .fifo_write_en_o(wr_en[1]), .fifo_data_o(fdata[1])
  );

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [IX_W-1:0] idx_of(input logic [AW_W-1:0] a);
    logic [AW_W-1:0] lo, hi;
    lo = (a >> 6) & 64'hF;
    hi = (a >> 10) & 64'hF;
`ifdef CACHE_IDX_HASH_EN
    return IX_W'(lo ^ hi);
`else
    return IX_W'(lo);
`endif
  endfunction

  // Reference model: what each instance should show in the next cycle.
  logic            exp_wr   [2] = '{1'b0, 1'b0};
  logic [DW-1:0]   exp_data [2] = '{'0, '0};
  logic [IX_W-1:0] exp_idx  [2] = '{'0, '0};
  bit              m_drain  [2] = '{1'b0, 1'b0};
  bit              m_last_aw[2] = '{1'b1, 1'b1};
  int              m_starve [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit acc, aw_wins, e_ar, e_aw;
      chk("push_strobe", k, DW'(wr_en[k]), DW'(exp_wr[k]));
      chk("descriptor",  k, fdata[k], exp_data[k]);
      chk("index",       k, DW'(index[k]), DW'(exp_idx[k]));
      chk("idle",        k, DW'(idle[k]), DW'(!exp_wr[k]));
      if (!rst_n) begin
        chk("arready_rst", k, DW'(arready[k]), '0);
        chk("awready_rst", k, DW'(awready[k]), '0);
        exp_wr[k] = 1'b0; exp_data[k] = '0; exp_idx[k] = '0;
        m_drain[k] = 1'b0; m_last_aw[k] = 1'b1; m_starve[k] = 0;
      end else begin
        acc = !m_drain[k] && !afull && !drain;
        if (arvalid && awvalid)
          aw_wins = (k == 0) ? !m_last_aw[k] : (m_starve[k] >= SMAX);
        else
          aw_wins = awvalid;
        e_ar = acc && arvalid && !aw_wins;
        e_aw = acc && awvalid && aw_wins;
        chk("arready", k, DW'(arready[k]), DW'(e_ar));
        chk("awready", k, DW'(awready[k]), DW'(e_aw));
        exp_wr[k] = e_ar || e_aw;
        if (e_ar) begin
          exp_data[k] = {1'b0, arid, araddr};
          exp_idx[k]  = idx_of(araddr);
          m_last_aw[k] = 1'b0;
          if (awvalid && m_starve[k] < SMAX) m_starve[k]++;
        end else if (e_aw) begin
          exp_data[k] = {1'b1, awid, awaddr};
          exp_idx[k]  = idx_of(awaddr);
          m_last_aw[k] = 1'b1;
          m_starve[k]  = 0;
        end
        m_drain[k] = drain;
      end
    end
  end

  task automatic step(input bit r, input bit ar, input bit aw, input bit af, input bit dr);
    @(posedge clk);
    #1;
    rst_n = r; arvalid = ar; awvalid = aw; afull = af; drain = dr;
    @(negedge clk);
  endtask

  logic [9:0] pat0, pat1;
  int n0, n1;

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset_idle", 0, DW'(idle[0]), DW'(1'b1));
    chk("reset_push", 0, DW'(wr_en[0]), '0);

    // Single read of 0x1A40, ID 5.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("single_rd_data", 0, fdata[0], {1'b0, 16'h0005, 64'h0000_0000_0000_1A40});
`ifdef CACHE_IDX_HASH_EN
    chk("single_rd_index", 0, DW'(index[0]), DW'(4'hF));
`else
    chk("single_rd_index", 0, DW'(index[0]), DW'(4'h9));
`endif

    // Single write.
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("single_wr_data", 1, fdata[1], {1'b1, 16'hB0B2, 64'hFFFF_0000_DEAD_BE40});

    // Fresh reset, then both channels valid for 10 cycles.
    step(0, 0, 0, 0, 0);
    pat0 = '0; pat1 = '0; n0 = 0; n1 = 0;
    for (int i = 0; i < 11; i++) begin
      step(1, i < 10, i < 10, 0, 0);
      if (wr_en[0] === 1'b1) begin pat0 = {pat0[8:0], fdata[0][DW-1]}; n0++; end
      if (wr_en[1] === 1'b1) begin pat1 = {pat1[8:0], fdata[1][DW-1]}; n1++; end
    end
    chk("rr_push_count",   0, DW'(n0), DW'(10));
    chk("rr_pattern",      0, DW'(pat0), DW'(10'b0101010101));
    chk("rdpri_push_count", 1, DW'(n1), DW'(10));
    chk("rdpri_pattern",   1, DW'(pat1), DW'(10'b0000100001));

    // FIFO almost full for three cycles.
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("afull_ready", 0, DW'(arready[0] | awready[0]), '0);
    chk("afull_ready", 1, DW'(arready[1] | awready[1]), '0);
    chk("afull_last_push", 0, DW'(wr_en[0]), DW'(1'b1));
    step(1, 1, 1, 1, 0);
    chk("afull_no_push", 0, DW'(wr_en[0]), '0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 0, 0);
    chk("afull_resume", 0, DW'(arready[0] | awready[0]), DW'(1'b1));
    chk("afull_resume", 1, DW'(arready[1] | awready[1]), DW'(1'b1));

    // Drain mid-stream.
    step(1, 1, 1, 0, 1);
    chk("drain_ready", 0, DW'(arready[0] | awready[0]), '0);
    chk("drain_ready", 1, DW'(arready[1] | awready[1]), '0);
    step(1, 1, 1, 0, 1);
    chk("drain_idle", 0, DW'(idle[0]), DW'(1'b1));
    chk("drain_idle", 1, DW'(idle[1]), DW'(1'b1));
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("drain_resume", 0, DW'(arready[0] | awready[0]), DW'(1'b1));
    step(1, 0, 0, 0, 0);

    // Reset arriving while a push is on the outputs.
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_forces_ready", 0, DW'(arready[0]), '0);
    chk("rst_push_visible", 0, DW'(wr_en[0]), DW'(1'b1));
    step(0, 1, 0, 0, 0);
    chk("rst_push_dropped", 0, DW'(wr_en[0]), '0);
    chk("rst_data_clear",   0, fdata[0], '0);
    chk("rst_index_clear",  1, DW'(index[1]), '0);
    chk("rst_idle",         1, DW'(idle[1]), DW'(1'b1));
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Parametrised front end of the DRAM cache request path. Accepts read (AR) and write (AW) address requests with full AXI valid/ready handshakes, arbitrates between them in a configurable mode, extracts the cache set index from a configurable bit field, and pushes one `{is_write, id, addr}` descriptor per accepted request into the request FIFO at up to one per cycle. It sits between the AXI slave port and the tag/request FIFO plus tag memory, and adds drain control for flush and maintenance sequencing.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, AXI address width.
- `ID_WIDTH`, 16, AXI ID width.
- `INDEX_WIDTH`, 4, set-index width.
- `INDEX_LSB`, 6, lowest address bit of the index field (line-offset bits below).
- `ARB_MODE`, 0, arbitration mode: 0 = round-robin, 1 = read priority with write starvation guard.
- `STARVE_MAX`, 4, in mode 1, AW arbitration losses before AW is forced to win; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `arid_i`  in  ID_WIDTH  read ID.
- `araddr_i`  in  ADDR_WIDTH  read address.
- `arvalid_i`  in  1  read request valid.
- `arready_o`  out  1  read request accepted.
- `awid_i`  in  ID_WIDTH  write ID.
- `awaddr_i`  in  ADDR_WIDTH  write address.
- `awvalid_i`  in  1  write request valid.
- `awready_o`  out  1  write request accepted.
- `drain_i`  in  1  stop accepting new requests while high.
- `idle_o`  out  1  no request in flight inside the block.
- `index_o`  out  INDEX_WIDTH  set index of the current descriptor, to tag memory.
- `fifo_afull_i`  in  1  FIFO almost full: at least 1 free entry remains when asserted.
- `fifo_write_en_o`  out  1  push strobe.
- `fifo_data_o`  out  ADDR_WIDTH+ID_WIDTH+1  descriptor: bit MSB = is_write (1 = write), then ID, then address in the LSBs.

## Operation
- States: `S_RUN` and `S_DRAIN`. Reset enters `S_RUN`.
- `accept_en` = `S_RUN` && !`fifo_afull_i` && !`drain_i`.
- Grant is combinational from the valids, the last-grant flag, and the starvation counter. The winner's ready equals `accept_en`. The loser's ready is 0.
- Ready may depend on valid. Ready never asserts for a channel whose valid is low.
- Mode 0: if only one channel is valid, it wins. If both are valid, the channel not granted last wins. The last-grant flag resets to AW, so AR wins the first tie.
- Mode 1: AR wins ties unless `starve_cnt == STARVE_MAX`, in which case AW wins.
  - `starve_cnt` increments, saturating, on each AR handshake while `awvalid_i` is high.
  - `starve_cnt` clears on any AW handshake.
- On a handshake, the descriptor and index are captured into output registers in the same edge.
- Index: `addr[INDEX_LSB +: INDEX_WIDTH]`, or the hashed form (see Configuration).
- `drain_i` high in `S_RUN` → `S_DRAIN`, which drops acceptance immediately.
  - `S_DRAIN` → `S_RUN` when `drain_i` is low.
  - `idle_o` = !`fifo_write_en_o` (registered push stage empty) in any state.
- Reset mid-operation: the pending push is discarded, not completed. The counter and last-grant flag reinitialise.

## Timing
- Latency: handshake in cycle N → `fifo_write_en_o`=1 with `fifo_data_o`/`index_o` in cycle N+1. Throughput is 1 request per cycle.
- `fifo_write_en_o` is high exactly one cycle per handshake. It is never high without a prior handshake.
- `index_o` and `fifo_data_o` hold their last value when there is no push.
- `fifo_afull_i` assertion in cycle N blocks handshakes in cycle N. A push already registered completes; this is covered by the FIFO's 1-entry slack.
- Reset values: `arready_o`=0, `awready_o`=0 (forced while `rst_n` is low), `fifo_write_en_o`=0, `fifo_data_o`=0, `index_o`=0, `idle_o`=1.

## Configuration
- `CACHE_IDX_HASH_EN` defined: index = `addr[INDEX_LSB +: INDEX_WIDTH] ^ addr[INDEX_LSB+INDEX_WIDTH +: INDEX_WIDTH]`. Requires `INDEX_LSB + 2*INDEX_WIDTH <= ADDR_WIDTH`.
- `CACHE_IDX_HASH_EN` undefined: index is the plain slice `addr[INDEX_LSB +: INDEX_WIDTH]`.
- The descriptor always carries the unmodified address.

## Structure
- Shared package `cache_pkg`:
  - State enum (`S_RUN`, `S_DRAIN`).
  - Arbitration mode constants `ARB_RR` = 0 and `ARB_RDPRI` = 1.
  - Descriptor field offsets, derived from `ADDR_WIDTH`/`ID_WIDTH`.
- One sub-module, `cache_idx_fn`: combinational index extraction, including the hash option. It is reused later by the tag path.

## Test plan
- Single read: `araddr_i`=0x0000_0000_0000_1A40, `arid_i`=0x0005, no hash → handshake in cycle N; in N+1, push with `fifo_data_o`={0, 0x0005, 0x...1A40} and `index_o`=0x9.
- Mode 0, both channels valid for 4 cycles → grants alternate AR, AW, AR, AW with 4 consecutive pushes and is_write pattern 0,1,0,1.
- Mode 1, `STARVE_MAX`=4, both channels continuously valid → grant sequence AR×4, AW, AR×4, AW.
- `fifo_afull_i` high for 3 cycles with both channels valid → both readys 0 for those cycles, no new push beyond the one already registered; acceptance resumes the cycle `fifo_afull_i` falls.
- `drain_i` asserted mid-stream → readys drop in the same cycle; `idle_o`=1 one cycle later; traffic resumes after `drain_i` deasserts.
- `CACHE_IDX_HASH_EN` build, address bits[9:6]=0x9 and bits[13:10]=0x6 → `index_o`=0xF; reset asserted during a push cycle → all outputs return to reset values on the next edge.
